word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter LSB_FIRST, default 0: 0 = byte wordIn[15:8] sent first; 1 = byte wordIn[7:0] sent first.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 wordIn  input  16  word from the upstream 16-bit mux stage (muxed output).
REQ-005 wordValid  input  1  wordIn holds a word to transfer.
REQ-006 wordReady  output  1  block accepts wordIn this cycle; transfer = wordValid & wordReady at clock edge.
REQ-007 byteOut  output  8  byte to the 8-bit datapath bus.
REQ-008 byteValid  output  1  byteOut holds a valid byte.
REQ-009 byteReady  input  1  consumer takes byteOut; transfer = byteValid & byteReady at clock edge.
REQ-010 byteLast  output  1  high with the second byte of each word.

Function
REQ-011 FSM states IDLE, FIRST, SECOND; a 16-bit main register holds the word being serialized.
REQ-012 IDLE: byteValid=0; on word transfer, load main register, go to FIRST at the next edge.
REQ-013 FIRST: byteValid=1, byteLast=0, byteOut = first byte per LSB_FIRST; on byte transfer, go to SECOND.
REQ-014 SECOND: byteValid=1, byteLast=1, byteOut = other byte; on byte transfer, go to FIRST if a next word is available (REQ-018), else IDLE.
REQ-015 Without byte transfer, state, byteOut, byteLast are held stable (no change while byteValid=1 and byteReady=0).
REQ-016 byteOut, byteValid, byteLast driven from registers/state only; no combinational path from byteReady or wordValid to them.
REQ-017 Latency: word accepted at edge N -> first byte valid in cycle N+1.
REQ-018 Main register is "free this cycle" in IDLE, or in SECOND with byteReady=1; a word arriving then loads the main register directly.
REQ-019 Byte order within a word and word order across words are never reordered; no word dropped or duplicated.
REQ-020 byteValid deasserts only after a byteLast transfer with no next word available.

Reset
REQ-021 rst=1 forces, asynchronously: state IDLE, byteValid=0, byteLast=0, byteOut=8'h00, main register 16'h0000, hold register empty and 16'h0000.
REQ-022 wordReady during reset = 0.
REQ-023 Reset mid-word discards the partially sent word and any held word; after rst falls, first accepted word starts at FIRST.

Configuration
REQ-024 Macro WORD_SERIALIZER_SKID_EN enables a one-word hold register.
REQ-025 Without macro: wordReady = (state==IDLE) & ~rst; sustained rate 2 bytes per 3 cycles.
REQ-026 With macro: wordReady = ~holdFull & ~rst; word accepted when main register not free loads hold register; on SECOND byte transfer with hold full, hold moves to main register, state FIRST, hold empties; sustained rate 1 byte/cycle.
REQ-027 With macro, simultaneous hold-to-main move and new word arrival: new word goes into the emptying hold register (hold stays full).

Verification
REQ-028 Reset, then wordIn=16'hA55A, wordValid pulse, byteReady=1 -> bytes 8'hA5 (byteLast=0), 8'h5A (byteLast=1), then byteValid=0.
REQ-029 LSB_FIRST=1, wordIn=16'h1234 -> bytes 8'h34 then 8'h12 (byteLast=1).
REQ-030 byteReady=0 for 5 cycles in FIRST with word 16'hBEEF -> byteOut stays 8'hBE, byteValid=1, wordReady=0 (no macro).
REQ-031 Macro on, wordValid=1 continuously with 16'h0102,16'h0304,16'h0506, byteReady=1 -> 8'h01..8'h06 on consecutive cycles, byteValid never drops.
REQ-032 Macro off, same stream -> same byte sequence with one idle cycle after each byteLast; wordReady high only in IDLE.
REQ-033 rst asserted while SECOND of 16'hCAFE and hold full (macro on) -> byteValid=0 immediately; next word 16'h7788 yields 8'h77, 8'h88 only.

Source files
------------

// File: rtl/word_serializer_if.sv
// Word-in / byte-out handshake bundle for word_serializer.
// The serializer uses the "master" modport (it masters the byte bus and
// answers the word handshake); the environment uses "slave".
interface word_serializer_if;
  logic [15:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        byteReady;
  logic        byteLast;

  modport master (
    input  wordIn, wordValid, byteReady,
    output wordReady, byteOut, byteValid, byteLast
  );

  modport slave (
    output wordIn, wordValid, byteReady,
    input  wordReady, byteOut, byteValid, byteLast
  );
endinterface

// File: rtl/word_serializer.sv
// word_serializer: splits 16-bit words into two bytes on an 8-bit
// valid/ready bus. LSB_FIRST picks which half goes out first; the second
// byte of each word is flagged with byteLast.
// Optional feature: define WORD_SERIALIZER_SKID_EN to add a one-word hold
// register so words can be accepted while a word is being sent, giving
// a sustained 1 byte/cycle. Without it, words are accepted only in IDLE.
module word_serializer #(
  parameter bit LSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               rst,
  word_serializer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [15:0] mainReg;
  logic [15:0] mainNext;
  logic        wordXfer;
  logic        byteXfer;
  logic [7:0]  firstByte;
  logic [7:0]  secondByte;

`ifdef WORD_SERIALIZER_SKID_EN
  logic [15:0] holdReg;
  logic [15:0] holdNext;
  logic        holdFull;
  logic        holdFullNext;

  assign bus.wordReady = ~holdFull & ~rst;
`else
  assign bus.wordReady = (state == IDLE) & ~rst;
`endif

  assign wordXfer   = bus.wordValid & bus.wordReady;
  assign byteXfer   = bus.byteValid & bus.byteReady;

  assign firstByte  = LSB_FIRST ? mainReg[7:0]  : mainReg[15:8];
  assign secondByte = LSB_FIRST ? mainReg[15:8] : mainReg[7:0];

  // Byte-side outputs depend only on state and the main register, never on
  // byteReady or wordValid, so they stay stable while the consumer stalls.
  assign bus.byteValid = (state != IDLE);
  assign bus.byteLast  = (state == SECOND);
  assign bus.byteOut   = (state == FIRST)  ? firstByte  :
                         (state == SECOND) ? secondByte : 8'h00;

  // State and main word register; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mainReg <= 16'h0000;
    end else begin
      state   <= stateNext;
      mainReg <= mainNext;
    end
  end

`ifdef WORD_SERIALIZER_SKID_EN
  // Hold register buffering the next word while the main word drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdReg  <= 16'h0000;
      holdFull <= 1'b0;
    end else begin
      holdReg  <= holdNext;
      holdFull <= holdFullNext;
    end
  end
`endif

  // Next-state logic: walk FIRST -> SECOND per byte transfer and reload the
  // main register whenever it frees up and a next word is available.
  always_comb begin
    stateNext = state;
    mainNext  = mainReg;
`ifdef WORD_SERIALIZER_SKID_EN
    holdNext     = holdReg;
    holdFullNext = holdFull;
`endif
    case (state)
      IDLE: begin
        if (wordXfer) begin
          mainNext  = bus.wordIn;
          stateNext = FIRST;
        end
      end
      FIRST: begin
        if (byteXfer) begin
          stateNext = SECOND;
        end
`ifdef WORD_SERIALIZER_SKID_EN
        if (wordXfer) begin
          holdNext     = bus.wordIn;
          holdFullNext = 1'b1;
        end
`endif
      end
      SECOND: begin
        if (byteXfer) begin
`ifdef WORD_SERIALIZER_SKID_EN
          if (holdFull) begin
            mainNext     = holdReg;
            stateNext    = FIRST;
            holdFullNext = wordXfer;
            if (wordXfer) begin
              holdNext = bus.wordIn;
            end
          end else if (wordXfer) begin
            mainNext  = bus.wordIn;
            stateNext = FIRST;
          end else begin
            stateNext = IDLE;
          end
`else
          if (wordXfer) begin
            mainNext  = bus.wordIn;
            stateNext = FIRST;
          end else begin
            stateNext = IDLE;
          end
`endif
        end else begin
`ifdef WORD_SERIALIZER_SKID_EN
          if (wordXfer) begin
            holdNext     = bus.wordIn;
            holdFullNext = 1'b1;
          end
`endif
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_word_serializer.sv
// Testbench for word_serializer. Two instances: dut0 sends the high byte
// first, dut1 the low byte first. A monitor records every byte transfer;
// each test task pushes expected bytes into a queue and compares them
// against the recorded transfers. Builds with or without
// WORD_SERIALIZER_SKID_EN; timing expectations follow that macro.
module tb_word_serializer;

`ifdef WORD_SERIALIZER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  word_serializer_if bus0 ();
  word_serializer_if bus1 ();

  word_serializer #(.LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  word_serializer #(.LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int testsRun    = 0;
  int testsFailed = 0;

  logic [8:0] expQ0[$];
  logic [8:0] expQ1[$];

  logic [8:0] obsMem0 [0:255];
  int         obsCyc0 [0:255];
  logic [8:0] obsMem1 [0:255];
  int         obsWr0     = 0;
  int         obsWr1     = 0;
  int         obsRd0     = 0;
  int         obsRd1     = 0;
  int         cycleCount = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Monitor: record {byteLast, byteOut} and cycle of every byte transfer.
  always @(negedge clk) begin
    cycleCount <= cycleCount + 1;
    if (!rst && bus0.byteValid && bus0.byteReady) begin
      obsMem0[obsWr0] <= {bus0.byteLast, bus0.byteOut};
      obsCyc0[obsWr0] <= cycleCount;
      obsWr0          <= obsWr0 + 1;
    end
    if (!rst && bus1.byteValid && bus1.byteReady) begin
      obsMem1[obsWr1] <= {bus1.byteLast, bus1.byteOut};
      obsWr1          <= obsWr1 + 1;
    end
  end

  // Reset values while rst is held, then ready-to-accept after release.
  task automatic test_reset;
    bus0.wordIn = 16'h0000; bus0.wordValid = 1'b0; bus0.byteReady = 1'b1;
    bus1.wordIn = 16'h0000; bus1.wordValid = 1'b0; bus1.byteReady = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (bus0.byteValid !== 1'b0 || bus0.byteLast !== 1'b0 || bus0.byteOut !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got valid=%b last=%b byte=%h, expected 0 0 00",
               bus0.byteValid, bus0.byteLast, bus0.byteOut);
    end
    testsRun++;
    if (bus0.wordReady !== 1'b0 || bus1.wordReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_wordReady: got %b/%b expected 0/0", bus0.wordReady, bus1.wordReady);
    end
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if (bus1.byteValid !== 1'b0 || bus1.byteOut !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset_dut1: got valid=%b byte=%h expected 0 00", bus1.byteValid, bus1.byteOut);
    end
    rst = 1'b0;
    #1;
    testsRun++;
    if (bus0.wordReady !== 1'b1 || bus0.byteValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: got ready=%b valid=%b expected 1 0", bus0.wordReady, bus0.byteValid);
    end
  endtask

  // Single word A55A, high byte first, with latency and return to idle.
  task automatic test_basic;
    logic [8:0] exp;
    logic [8:0] got;
    @(posedge clk); #1;
    bus0.wordIn = 16'hA55A; bus0.wordValid = 1'b1; bus0.byteReady = 1'b1;
    expQ0.push_back({1'b0, 8'hA5});
    expQ0.push_back({1'b1, 8'h5A});
    @(posedge clk); #1;
    bus0.wordValid = 1'b0;
    testsRun++;
    if (bus0.byteValid !== 1'b1 || bus0.byteOut !== 8'hA5 || bus0.byteLast !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_latency: got valid=%b byte=%h last=%b expected 1 a5 0",
               bus0.byteValid, bus0.byteOut, bus0.byteLast);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    testsRun++;
    if (bus0.byteValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_idle: got byteValid=%b expected 0", bus0.byteValid);
    end
    for (int c = 0; c < 50 && (obsWr0 - obsRd0) < expQ0.size(); c++) @(posedge clk);
    #1;
    testsRun++;
    if ((obsWr0 - obsRd0) < expQ0.size()) begin
      testsFailed++;
      $display("[TB] FAIL basic_timeout: got %0d bytes expected %0d", obsWr0 - obsRd0, expQ0.size());
      expQ0.delete(); obsRd0 = obsWr0;
    end
    while (expQ0.size() > 0) begin
      exp = expQ0.pop_front(); got = obsMem0[obsRd0]; obsRd0++;
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL basic_byte: got last/byte %h expected %h", got, exp);
      end
    end
  endtask

  // Low-byte-first instance with word 1234.
  task automatic test_lsb_first;
    logic [8:0] exp;
    logic [8:0] got;
    @(posedge clk); #1;
    bus1.wordIn = 16'h1234; bus1.wordValid = 1'b1; bus1.byteReady = 1'b1;
    expQ1.push_back({1'b0, 8'h34});
    expQ1.push_back({1'b1, 8'h12});
    @(posedge clk); #1;
    bus1.wordValid = 1'b0;
    for (int c = 0; c < 50 && (obsWr1 - obsRd1) < expQ1.size(); c++) @(posedge clk);
    #1;
    testsRun++;
    if ((obsWr1 - obsRd1) < expQ1.size()) begin
      testsFailed++;
      $display("[TB] FAIL lsb_timeout: got %0d bytes expected %0d", obsWr1 - obsRd1, expQ1.size());
      expQ1.delete(); obsRd1 = obsWr1;
    end
    while (expQ1.size() > 0) begin
      exp = expQ1.pop_front(); got = obsMem1[obsRd1]; obsRd1++;
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL lsb_byte: got last/byte %h expected %h", got, exp);
      end
    end
  endtask

  // Consumer stall in FIRST with word BEEF: output frozen for 5 cycles.
  task automatic test_stall;
    logic [8:0] exp;
    logic [8:0] got;
    @(posedge clk); #1;
    bus0.wordIn = 16'hBEEF; bus0.wordValid = 1'b1; bus0.byteReady = 1'b0;
    expQ0.push_back({1'b0, 8'hBE});
    expQ0.push_back({1'b1, 8'hEF});
    @(posedge clk); #1;
    bus0.wordValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      testsRun++;
      if (bus0.byteOut !== 8'hBE || bus0.byteValid !== 1'b1 || bus0.byteLast !== 1'b0 ||
          bus0.wordReady !== SKID) begin
        testsFailed++;
        $display("[TB] FAIL stall_hold: cycle %0d got byte=%h valid=%b last=%b ready=%b expected be 1 0 %b",
                 i, bus0.byteOut, bus0.byteValid, bus0.byteLast, bus0.wordReady, SKID);
      end
    end
    @(posedge clk); #1;
    bus0.byteReady = 1'b1;
    for (int c = 0; c < 50 && (obsWr0 - obsRd0) < expQ0.size(); c++) @(posedge clk);
    #1;
    testsRun++;
    if ((obsWr0 - obsRd0) < expQ0.size()) begin
      testsFailed++;
      $display("[TB] FAIL stall_timeout: got %0d bytes expected %0d", obsWr0 - obsRd0, expQ0.size());
      expQ0.delete(); obsRd0 = obsWr0;
    end
    while (expQ0.size() > 0) begin
      exp = expQ0.pop_front(); got = obsMem0[obsRd0]; obsRd0++;
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL stall_byte: got last/byte %h expected %h", got, exp);
      end
    end
  endtask

  // Continuous stream 0102/0304/0506: byte order plus cycle spacing
  // (back-to-back with the hold register, one idle cycle per word without).
  task automatic test_stream;
    logic [15:0] words [0:2];
    logic [8:0]  exp;
    logic [8:0]  got;
    logic        accepted;
    int          idx;
    int          base;
    int          gap;
    int          gapExp;
    words[0] = 16'h0102; words[1] = 16'h0304; words[2] = 16'h0506;
    for (int i = 0; i < 3; i++) begin
      expQ0.push_back({1'b0, words[i][15:8]});
      expQ0.push_back({1'b1, words[i][7:0]});
    end
    base = obsRd0;
    idx  = 0;
    @(posedge clk); #1;
    bus0.wordIn = words[0]; bus0.wordValid = 1'b1; bus0.byteReady = 1'b1;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      @(negedge clk);
      accepted = bus0.wordReady;
      testsRun++;
      if (bus0.wordReady !== (SKID ? !bus0.byteLast : !bus0.byteValid)) begin
        testsFailed++;
        $display("[TB] FAIL stream_wordReady: got %b with valid=%b last=%b", bus0.wordReady,
                 bus0.byteValid, bus0.byteLast);
      end
      @(posedge clk); #1;
      if (accepted) begin
        idx++;
        if (idx < 3) bus0.wordIn = words[idx];
        else bus0.wordValid = 1'b0;
      end
    end
    bus0.wordValid = 1'b0;
    for (int c = 0; c < 60 && (obsWr0 - obsRd0) < expQ0.size(); c++) @(posedge clk);
    #1;
    testsRun++;
    if ((obsWr0 - obsRd0) < expQ0.size()) begin
      testsFailed++;
      $display("[TB] FAIL stream_timeout: got %0d bytes expected %0d", obsWr0 - obsRd0, expQ0.size());
      expQ0.delete(); obsRd0 = obsWr0;
    end else begin
      for (int i = 1; i < 6; i++) begin
        gap    = obsCyc0[base + i] - obsCyc0[base + i - 1];
        gapExp = (SKID || (i % 2 == 1)) ? 1 : 2;
        testsRun++;
        if (gap !== gapExp) begin
          testsFailed++;
          $display("[TB] FAIL stream_gap: byte %0d got %0d cycles expected %0d", i, gap, gapExp);
        end
      end
    end
    while (expQ0.size() > 0) begin
      exp = expQ0.pop_front(); got = obsMem0[obsRd0]; obsRd0++;
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL stream_byte: got last/byte %h expected %h", got, exp);
      end
    end
  endtask

  // Random words under random consumer back-pressure; outputs must hold
  // while stalled and every byte must arrive in order exactly once.
  task automatic test_back_to_back;
    logic [15:0] words [0:5];
    logic [8:0]  exp;
    logic [8:0]  got;
    logic        accepted;
    logic        prevStall;
    logic [8:0]  prevOut;
    int          idx;
    for (int i = 0; i < 6; i++) begin
      words[i] = 16'($urandom);
      expQ0.push_back({1'b0, words[i][15:8]});
      expQ0.push_back({1'b1, words[i][7:0]});
    end
    idx       = 0;
    prevStall = 1'b0;
    prevOut   = 9'h000;
    @(posedge clk); #1;
    bus0.wordIn = words[0]; bus0.wordValid = 1'b1;
    bus0.byteReady = 1'($urandom_range(0, 1));
    for (int c = 0; c < 300 && (idx < 6 || bus0.byteValid); c++) begin
      @(negedge clk);
      accepted = bus0.wordReady & bus0.wordValid;
      if (prevStall) begin
        testsRun++;
        if ({bus0.byteLast, bus0.byteOut} !== prevOut || bus0.byteValid !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL b2b_stable: got valid=%b last/byte %h expected 1 %h",
                   bus0.byteValid, {bus0.byteLast, bus0.byteOut}, prevOut);
        end
      end
      prevStall = bus0.byteValid & ~bus0.byteReady;
      prevOut   = {bus0.byteLast, bus0.byteOut};
      @(posedge clk); #1;
      bus0.byteReady = 1'($urandom_range(0, 1));
      if (accepted) begin
        idx++;
        if (idx < 6) bus0.wordIn = words[idx];
        else bus0.wordValid = 1'b0;
      end
    end
    bus0.wordValid = 1'b0;
    bus0.byteReady = 1'b1;
    for (int c = 0; c < 60 && (obsWr0 - obsRd0) < expQ0.size(); c++) @(posedge clk);
    #1;
    testsRun++;
    if ((obsWr0 - obsRd0) < expQ0.size()) begin
      testsFailed++;
      $display("[TB] FAIL b2b_timeout: got %0d bytes expected %0d", obsWr0 - obsRd0, expQ0.size());
      expQ0.delete(); obsRd0 = obsWr0;
    end
    while (expQ0.size() > 0) begin
      exp = expQ0.pop_front(); got = obsMem0[obsRd0]; obsRd0++;
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL b2b_byte: got last/byte %h expected %h", got, exp);
      end
    end
  endtask

  // Reset during SECOND of CAFE (with a word held when the hold register
  // exists): everything in flight is discarded; 7788 then goes out alone.
  task automatic test_reset_midword;
    logic [8:0] exp;
    logic [8:0] got;
    @(posedge clk); #1;
    bus0.wordIn = 16'hCAFE; bus0.wordValid = 1'b1; bus0.byteReady = 1'b1;
    expQ0.push_back({1'b0, 8'hCA});
    @(posedge clk); #1;
    bus0.wordIn = 16'h1111;
    @(posedge clk); #1;
    bus0.wordValid = 1'b0; bus0.byteReady = 1'b0;
    testsRun++;
    if (bus0.byteOut !== 8'hFE || bus0.byteLast !== 1'b1 || bus0.wordReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_pre: got byte=%h last=%b ready=%b expected fe 1 0",
               bus0.byteOut, bus0.byteLast, bus0.wordReady);
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (bus0.byteValid !== 1'b0 || bus0.byteLast !== 1'b0 || bus0.byteOut !== 8'h00 ||
        bus0.wordReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_async: got valid=%b last=%b byte=%h ready=%b expected 0 0 00 0",
               bus0.byteValid, bus0.byteLast, bus0.byteOut, bus0.wordReady);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.byteReady = 1'b1;
    @(posedge clk); #1;
    bus0.wordIn = 16'h7788; bus0.wordValid = 1'b1;
    expQ0.push_back({1'b0, 8'h77});
    expQ0.push_back({1'b1, 8'h88});
    @(posedge clk); #1;
    bus0.wordValid = 1'b0;
    for (int c = 0; c < 50 && (obsWr0 - obsRd0) < expQ0.size(); c++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    testsRun++;
    if ((obsWr0 - obsRd0) != expQ0.size()) begin
      testsFailed++;
      $display("[TB] FAIL midrst_count: got %0d bytes expected %0d", obsWr0 - obsRd0, expQ0.size());
      expQ0.delete(); obsRd0 = obsWr0;
    end
    while (expQ0.size() > 0) begin
      exp = expQ0.pop_front(); got = obsMem0[obsRd0]; obsRd0++;
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL midrst_byte: got last/byte %h expected %h", got, exp);
      end
    end
  endtask

  // Test sequence and summary.
  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_stall();
    test_stream();
    test_back_to_back();
    test_reset_midword();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard time limit in case a wait never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
